// File: rtl/timingskew_ramp_ctrl.sv
// timingskew_ramp_ctrl
// Multi-channel sequencer for the rise/fall timing-skew delay stones. Each
// channel holds a current code (driven on s) and a target code. Ramp writes
// move the current code one LSB per shared step tick. Direct writes load the
// code at once. The supply/substrate pins pass through with no logic use.
module timingskew_ramp_ctrl #(
  parameter int BITS        = 2,
  parameter int CHANNELS    = 4,
  parameter int STEP_CYCLES = 8,
  parameter int POR_CODE    = 0,
  parameter bit RETARGET    = 1'b1,
  localparam int CHW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int TW         = $clog2(STEP_CYCLES)
) (
  input  logic                     CELCLK,
  input  logic                     CELRSTB,
  input  logic                     CELV,
  input  logic                     CELG,
  input  logic                     CELSUB,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [CHW-1:0]           wr_ch,
  input  logic [BITS-1:0]          wr_code,
  input  logic                     wr_direct,
  input  logic                     hold,
  output logic [CHANNELS*BITS-1:0] s,
  output logic [CHANNELS-1:0]      busy,
  output logic [CHANNELS-1:0]      settled,
  output logic                     wr_err
);

  localparam logic [BITS-1:0] POR_VAL  = BITS'(POR_CODE);
  localparam logic [TW-1:0]   TMR_LAST = TW'(STEP_CYCLES - 1);

  // state registers
  logic [BITS-1:0]     r_cur [CHANNELS];
  logic [BITS-1:0]     r_tgt [CHANNELS];
  logic [TW-1:0]       r_tmr;
  logic [CHANNELS-1:0] r_settled;
  logic                r_wr_err;

  // combinational next-state
  logic [BITS-1:0]     w_cur_nxt [CHANNELS];
  logic [BITS-1:0]     w_tgt_nxt [CHANNELS];
  logic [BITS-1:0]     w_step    [CHANNELS];
  logic [CHANNELS-1:0] w_land;
  logic [CHANNELS-1:0] w_settled_nxt;
  logic [CHANNELS-1:0] w_busy;
  logic [TW-1:0]       w_tmr_nxt;
  logic                w_wr_err_nxt;
  logic                w_busy_sel;
  logic                w_ch_oob;
  logic                w_ready;
  logic                w_accept;
  logic                w_any_busy;
  logic                w_tick;

  // Supply/substrate pins are electrical pass-throughs only.
  logic w_unused_pins;
  assign w_unused_pins = &{1'b0, CELV, CELG, CELSUB};

  // An index beyond the last channel can only occur when CHANNELS is not a power of two.
  generate
    if (CHANNELS == (1 << CHW)) begin : g_oob_none
      assign w_ch_oob = 1'b0;
    end else begin : g_oob_cmp
      assign w_ch_oob = (wr_ch >= CHW'(CHANNELS));
    end
  endgenerate

  // Fan the current codes out onto the flat s bus and derive per-channel busy.
  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan_out
      assign s[g*BITS +: BITS] = r_cur[g];
      assign w_busy[g]         = (r_cur[g] != r_tgt[g]);
    end
  endgenerate

  // Pick out the busy flag of the addressed channel for write flow control.
  always_comb begin
    w_busy_sel = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (wr_ch == CHW'(k)) begin
        w_busy_sel = w_busy[k];
      end else begin
        w_busy_sel = w_busy_sel;
      end
    end
  end

  // Write accept: closed in reset, otherwise open unless a blocked retarget is pending.
  always_comb begin
    if (!CELRSTB) begin
      w_ready = 1'b0;
    end else if (RETARGET || w_ch_oob) begin
      w_ready = 1'b1;
    end else begin
      w_ready = ~w_busy_sel;
    end
  end

  // Shared step timer and per-channel ramp/write next-state.
  always_comb begin
    w_accept     = wr_valid & w_ready;
    w_any_busy   = |w_busy;
    w_tick       = w_any_busy & ~hold & (r_tmr == TMR_LAST);
    w_wr_err_nxt = w_accept & w_ch_oob;

    if (!w_any_busy) begin
      w_tmr_nxt = '0;
    end else if (hold) begin
      w_tmr_nxt = r_tmr;
    end else if (w_tick) begin
      w_tmr_nxt = '0;
    end else begin
      w_tmr_nxt = r_tmr + TW'(1);
    end

    for (int k = 0; k < CHANNELS; k++) begin
      // One LSB toward the pre-edge target; a non-busy channel never moves.
      if (w_tick && w_busy[k]) begin
        if (r_cur[k] < r_tgt[k]) begin
          w_step[k] = r_cur[k] + BITS'(1);
        end else begin
          w_step[k] = r_cur[k] - BITS'(1);
        end
      end else begin
        w_step[k] = r_cur[k];
      end
      w_land[k] = w_tick & w_busy[k] & (w_step[k] == r_tgt[k]);

      // A write to this channel takes the new target and suppresses any landing pulse.
      if (w_accept && !w_ch_oob && (wr_ch == CHW'(k))) begin
        w_tgt_nxt[k]     = wr_code;
        w_settled_nxt[k] = 1'b0;
        if (wr_direct) begin
          w_cur_nxt[k] = wr_code;
        end else begin
          w_cur_nxt[k] = w_step[k];
        end
      end else begin
        w_tgt_nxt[k]     = r_tgt[k];
        w_cur_nxt[k]     = w_step[k];
        w_settled_nxt[k] = w_land[k];
      end
    end
  end

  // State update with synchronous active-low reset.
  always_ff @(posedge CELCLK) begin
    if (!CELRSTB) begin
      for (int k = 0; k < CHANNELS; k++) begin
        r_cur[k] <= POR_VAL;
        r_tgt[k] <= POR_VAL;
      end
      r_tmr     <= '0;
      r_settled <= '0;
      r_wr_err  <= 1'b0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        r_cur[k] <= w_cur_nxt[k];
        r_tgt[k] <= w_tgt_nxt[k];
      end
      r_tmr     <= w_tmr_nxt;
      r_settled <= w_settled_nxt;
      r_wr_err  <= w_wr_err_nxt;
    end
  end

  assign wr_ready = w_ready;
  assign busy     = w_busy;
  assign settled  = r_settled;
  assign wr_err   = r_wr_err;

endmodule

// File: doc/timingskew_ramp_ctrl.md
# timingskew_ramp_ctrl

Parametrised multi-channel sequencer for the rise/fall timing-skew delay stones. Accepts per-channel target skew codes over a valid/ready write port and drives each channel's `s` code to its target. Moves are either one LSB per programmable step interval, to avoid large instantaneous delay jumps in the stepdown core, or a direct load. It sits between the core-state register logic and the per-channel skew stones and generalises the fixed 2-bit pin-controlled skew block.

## Interface
- `BITS`, 2, skew code width per channel (≥1)
- `CHANNELS`, 4, number of skew channels (≥1)
- `STEP_CYCLES`, 8, clock cycles per one-LSB ramp step (≥2)
- `POR_CODE`, 0, reset value of every channel's current and target code
- `RETARGET`, 1, 1: writes accepted while the addressed channel is ramping; 0: blocked
- `CELCLK`  in  1  clock; all state on rising edge
- `CELRSTB`  in  1  reset, synchronous, active-low
- `CELV`, `CELG`, `CELSUB`  in  1 each  supply/substrate pass pins; no functional use in RTL
- `wr_valid`  in  1  write request
- `wr_ready`  out  1  write accept
- `wr_ch`  in  max(1,$clog2(CHANNELS))  target channel index
- `wr_code`  in  BITS  target skew code
- `wr_direct`  in  1  1: load the code immediately, no ramp
- `hold`  in  1  freeze the step timer and all ramps
- `s`  out  CHANNELS*BITS  current codes; channel k occupies bits [k*BITS +: BITS]
- `busy`  out  CHANNELS  channel k current ≠ target
- `settled`  out  CHANNELS  one-cycle pulse when a ramp lands on target
- `wr_err`  out  1  one-cycle pulse: accepted write with `wr_ch` ≥ CHANNELS

## Operation
- **Per-channel state:** `cur[k]` and `tgt[k]`, each BITS wide.
  - `s` = `cur`.
  - `busy[k]` = (`cur[k]` != `tgt[k]`), combinational from registers.
- **Write accept:** `wr_valid & wr_ready` at an edge.
  - `wr_ready` is 0 while `CELRSTB`=0.
  - Otherwise `wr_ready` = 1 if `RETARGET`=1, else `~busy[wr_ch]`.
  - For an out-of-range `wr_ch`: `wr_ready`=1; the write is discarded and `wr_err` pulses.
- **Ramp write** (`wr_direct`=0): `tgt[ch]` ← `wr_code`. `cur` is unchanged by the write.
- **Direct write** (`wr_direct`=1): `tgt[ch]` and `cur[ch]` both ← `wr_code`. No `settled` pulse.
- **Write of a code equal to `cur`:** no busy, no pulse.
- **Shared step timer** (`tmr`), range 0..STEP_CYCLES-1:
  - Held at 0 when no channel is busy.
  - Frozen when `hold`=1.
  - Otherwise increments each edge.
  - A tick occurs when `tmr`=STEP_CYCLES-1 and `hold`=0; `tmr` wraps to 0 on the tick.
- **On a tick**, every busy channel moves `cur` one LSB toward `tgt` (±1 only, never wraps). `settled[k]` pulses the cycle after the edge where `cur[k]` reaches `tgt[k]`.
- **Simultaneous write and tick on the same channel:**
  - Ramp write: `cur` steps toward the pre-edge `tgt`, and `tgt` takes the new code.
  - Direct write: overrides the step.
  - In both cases, `settled` is suppressed if the step would have landed.
- **Retarget mid-ramp** (`RETARGET`=1): the ramp continues from the current `cur`, reversing direction if needed. Timer phase is not reset.
- **Reset** (`CELRSTB`=0 at an edge), including mid-ramp:
  - `cur` = `tgt` = `POR_CODE` for all channels; `tmr` = 0.
  - `settled` = 0, `wr_err` = 0, `busy` = 0.

## Timing
- **Reset values:** `s` = {CHANNELS{POR_CODE}}, `busy` = 0, `settled` = 0, `wr_err` = 0, `wr_ready` = 0 during reset.
- **Idle ramp:** a ramp write accepted at edge E0 while no channel is busy first changes `s` at E0+STEP_CYCLES.
  - A distance of d LSB lands at E0+d*STEP_CYCLES.
  - `settled` is high for the cycle after that edge.
- **Shared timer phase:** if another channel is already ramping, the first step occurs at the next shared tick, which is 1..STEP_CYCLES edges later.
- **Direct write:** visible on `s` one edge after accept.
- **`hold`:** adds exactly one cycle of delay per held cycle.
- **Registers:** all outputs except `busy` and `wr_ready` are registered.

## Test plan
Defaults for all scenarios: BITS=2, CHANNELS=4, STEP_CYCLES=4, POR_CODE=0.
- Reset 3 cycles, then release -> `s`=0x00, `busy`=0, `wr_ready` 0 during reset and 1 afterwards.
- Ramp write ch1 code 3 at E0 -> `s[3:2]` is 1@E4, 2@E8, 3@E12; `settled[1]` pulses the cycle after E12; `busy[1]` is high over E0..E12.
- Retarget (`RETARGET`=1): ch1 ramping 0→3, write code 0 when `cur`=2 -> `s[3:2]` goes 1 then 0 at consecutive ticks, single `settled` pulse. With `RETARGET`=0, the same write sees `wr_ready`=0 until `busy[1]` clears.
- Direct write ch2 code 2 while ch0 is ramping -> `s[5:4]`=2 one edge later, no `settled[2]`, ch0 ramp timing unchanged. A write with `wr_ch`=5 (3-bit port, CHANNELS=5 build) raises `wr_err` for one cycle with no state change.
- `hold` high for 6 cycles mid-ramp -> `s` frozen; the next step arrives exactly 6 cycles later than without `hold`.
- Reset asserted when ch3 `cur`=2 during a ramp to 3 -> at the next edge `s`=0, `busy`=0, no `settled` pulse.
